// File: rtl/pdp8_uart.sv
// Console teletype serial interface: 8N1/8N2 transmitter and 8N1 receiver
// sharing a 16x oversampling baud divider parameter.
module pdp8_uart #(
  parameter int BAUD_DIV  = 325,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int BIT_CLKS  = 16 * BAUD_DIV;
  localparam int STOP_CLKS = STOP_BITS * BIT_CLKS;
  localparam int TCW       = $clog2(STOP_CLKS);
  localparam int PW        = $clog2(BAUD_DIV);

  localparam logic [TCW-1:0] BIT_LAST  = TCW'(BIT_CLKS - 1);
  localparam logic [TCW-1:0] STOP_LAST = TCW'(STOP_CLKS - 1);
  localparam logic [PW-1:0]  PRE_LAST  = PW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t      r_tx_state, w_tx_state_nxt;
  logic [TCW-1:0] r_tx_cnt;
  logic [7:0]     r_tx_sh;
  logic [2:0]     r_tx_idx;
  logic           r_tx_end, r_tx_busy, r_tx_done, r_txd;
  logic           w_tx_accept, w_tx_end, w_txd_nxt, w_bit_end, w_stop_end;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_tx_state_nxt = r_tx_state;
    w_tx_end       = 1'b0;
    w_txd_nxt      = 1'b1;
    w_tx_accept    = (r_tx_state == TX_IDLE) && tx_start && !r_tx_busy;
    w_bit_end      = (r_tx_cnt == BIT_LAST);
    w_stop_end     = (r_tx_cnt == STOP_LAST);
    case (r_tx_state)
      TX_IDLE:  if (w_tx_accept) w_tx_state_nxt = TX_START;
      TX_START: begin
        w_txd_nxt = 1'b0;
        if (w_bit_end) w_tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        w_txd_nxt = r_tx_sh[r_tx_idx];
        if (w_bit_end && (r_tx_idx == 3'd7)) w_tx_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (w_stop_end) begin
          w_tx_state_nxt = TX_IDLE;
          w_tx_end       = 1'b1;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // Line, busy and done are registered one clock behind the FSM.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_sh    <= '0;
      r_tx_idx   <= '0;
      r_tx_end   <= 1'b0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_end   <= w_tx_end;
      r_tx_done  <= r_tx_end;
      r_txd      <= w_txd_nxt;
      if (w_tx_accept) begin
        r_tx_sh   <= tx_data;
        r_tx_busy <= 1'b1;
      end else if (r_tx_end) begin
        r_tx_busy <= 1'b0;
      end
      if ((r_tx_state == TX_IDLE) || ((r_tx_state != TX_STOP) && w_bit_end) || w_stop_end)
        r_tx_cnt <= '0;
      else
        r_tx_cnt <= r_tx_cnt + TCW'(1);
      if (r_tx_state == TX_START)
        r_tx_idx <= '0;
      else if ((r_tx_state == TX_DATA) && w_bit_end)
        r_tx_idx <= r_tx_idx + 3'd1;
    end
  end

  assign tx_busy = r_tx_busy;
  assign tx_done = r_tx_done;
  assign txd     = r_txd;

  // ---------------- receiver ----------------
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic          r_sync1, r_sync2;
  logic [PW-1:0] r_pre;
  logic [3:0]    r_tick;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_sh, r_rx_data;
  logic          r_rx_valid, r_rx_ferr;
  logic          w_rxs, w_sample, w_rx_load;

  assign w_rxs = r_sync2;

  // Mid-bit samples land on 1/16 ticks 8, 24, ... 152: tick phase 7 about to wrap.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_sample       = (r_pre == PRE_LAST) && (r_tick == 4'd7);
    w_rx_load      = 1'b0;
    case (r_rx_state)
      RX_IDLE:   if (!w_rxs) w_rx_state_nxt = RX_START;
      RX_START:  if (w_sample) w_rx_state_nxt = w_rxs ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_sample && (r_rx_idx == 3'd7)) w_rx_state_nxt = RX_STOP;
      RX_STOP: begin
        if (w_sample) begin
          w_rx_load      = 1'b1;
          w_rx_state_nxt = w_rxs ? RX_IDLE : RX_WAITHI;
        end
      end
      RX_WAITHI: if (w_rxs) w_rx_state_nxt = RX_IDLE;
      default:   w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_pre      <= '0;
      r_tick     <= '0;
      r_rx_idx   <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_sync1    <= rxd;
      r_sync2    <= r_sync1;
      r_rx_state <= w_rx_state_nxt;
      r_rx_valid <= w_rx_load;
      if ((r_rx_state == RX_IDLE) || (r_rx_state == RX_WAITHI)) begin
        r_pre  <= '0;
        r_tick <= '0;
      end else if (r_pre == PRE_LAST) begin
        r_pre  <= '0;
        r_tick <= r_tick + 4'd1;
      end else begin
        r_pre  <= r_pre + PW'(1);
      end
      if (r_rx_state == RX_START)
        r_rx_idx <= '0;
      else if ((r_rx_state == RX_DATA) && w_sample) begin
        r_rx_idx <= r_rx_idx + 3'd1;
        r_rx_sh  <= {w_rxs, r_rx_sh[7:1]};
      end
      if (w_rx_load) begin
        r_rx_data <= r_rx_sh;
        r_rx_ferr <= ~w_rxs;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_ferr  = r_rx_ferr;

endmodule

// File: tb/tb_pdp8_uart.sv
// Directed bench for pdp8_uart at BAUD_DIV=4 (64 clocks per bit), 1 stop bit.
module tb_pdp8_uart;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, txd;
  logic       rxd, rxd_drv, loop;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  int checks   = 0;
  int failures = 0;

  logic [8:0] rx_log[$];
  int done_cnt = 0;
  int txd_low  = 0;

  assign rxd = loop ? txd : rxd_drv;

  pdp8_uart #(.BAUD_DIV(4), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd),
    .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr)
  );

  always #5 clk = ~clk;

  // Observers sample mid-cycle; each received character is logged as {ferr, data}.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_log.push_back({rx_ferr, rx_data});
    if (tx_done === 1'b1) done_cnt++;
    if (txd === 1'b0) txd_low++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rxd_drv = 1'b0;
    step(64);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      step(64);
    end
    rxd_drv = stop;
    step(64);
  endtask

  task automatic test_reset();
    int base_rx, base_low;
    reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00; rxd_drv = 1'b1; loop = 1'b0;
    step(3);
    checks++; if (txd !== 1'b1)      begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (tx_busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    checks++; if (tx_done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_ferr !== 1'b0)  begin failures++; $display("FAIL reset_rx_ferr got=%b exp=0", rx_ferr); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    reset = 1'b0;
    base_rx = rx_log.size(); base_low = txd_low;
    step(1000);
    checks++; if (rx_log.size() !== base_rx) begin failures++; $display("FAIL idle_rx_valid got=%0d exp=%0d", rx_log.size(), base_rx); end
    checks++; if (txd_low !== base_low) begin failures++; $display("FAIL idle_txd_low got=%0d exp=%0d", txd_low, base_low); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", tx_busy); end
  endtask

  task automatic test_tx_frame();
    logic [9:0] frame;
    int err[10];
    int busy_err, early_done, base_done, base_low;
    frame = {1'b1, 8'h8D, 1'b0};
    for (int j = 0; j < 10; j++) err[j] = 0;
    busy_err = 0; early_done = 0;
    base_done = done_cnt;
    tx_data = 8'h8D; tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    for (int e = 1; e <= 640; e++) begin
      step(1);
      if (txd !== frame[(e-1)/64]) err[(e-1)/64]++;
      if (tx_busy !== 1'b1) busy_err++;
      if (tx_done !== 1'b0) early_done++;
      if (e == 100) begin tx_start = 1'b1; tx_data = 8'h00; end
      if (e == 101) tx_start = 1'b0;
    end
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (err[j] != 0) begin failures++; $display("FAIL tx_bit%0d wrong_clocks=%0d exp_level=%b exp_wrong=0", j, err[j], frame[j]); end
    end
    checks++; if (busy_err != 0)   begin failures++; $display("FAIL tx_busy_during got_low_clocks=%0d exp=0", busy_err); end
    checks++; if (early_done != 0) begin failures++; $display("FAIL tx_done_early got=%0d exp=0", early_done); end
    step(1);
    checks++; if (tx_done !== 1'b1) begin failures++; $display("FAIL tx_done_641 got=%b exp=1", tx_done); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL tx_busy_641 got=%b exp=0", tx_busy); end
    step(1);
    checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL tx_done_width got=%b exp=0", tx_done); end
    base_low = txd_low;
    step(300);
    checks++; if (done_cnt - base_done != 1) begin failures++; $display("FAIL tx_done_count got=%0d exp=1", done_cnt - base_done); end
    checks++; if (txd_low !== base_low) begin failures++; $display("FAIL tx_ignored_start got_low=%0d exp=0", txd_low - base_low); end
  endtask

  task automatic test_back_to_back();
    int base_rx, base_done;
    logic [7:0] exp_d[3];
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h55;
    loop = 1'b1;
    base_rx = rx_log.size(); base_done = done_cnt;
    tx_data = 8'h00; tx_start = 1'b1;
    step(1);
    tx_data = 8'hFF;
    for (int e = 1; e <= 1285; e++) begin
      step(1);
      if (e == 641 || e == 642 || e == 1283 || e == 1284) begin
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL b2b_gap_e%0d got=%b exp=1", e, txd); end
      end
      if (e == 643 || e == 1285) begin
        checks++; if (txd !== 1'b0) begin failures++; $display("FAIL b2b_start_e%0d got=%b exp=0", e, txd); end
      end
      if (e == 643) tx_data = 8'h55;
      if (e == 1285) tx_start = 1'b0;
    end
    step(700);
    checks++; if (rx_log.size() - base_rx != 3) begin failures++; $display("FAIL b2b_rx_count got=%0d exp=3", rx_log.size() - base_rx); end
    for (int i = 0; i < 3; i++) begin
      if (rx_log.size() > base_rx + i) begin
        checks++;
        if (rx_log[base_rx+i] !== {1'b0, exp_d[i]}) begin
          failures++; $display("FAIL b2b_rx%0d got=%h exp=%h", i, rx_log[base_rx+i], {1'b0, exp_d[i]});
        end
      end
    end
    checks++; if (done_cnt - base_done != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", done_cnt - base_done); end
    loop = 1'b0;
  endtask

  task automatic test_glitch();
    int base_rx;
    base_rx = rx_log.size();
    rxd_drv = 1'b0;
    step(20);
    rxd_drv = 1'b1;
    step(800);
    checks++; if (rx_log.size() != base_rx) begin failures++; $display("FAIL glitch_rx_valid got=%0d exp=0", rx_log.size() - base_rx); end
    send_rx(8'h41, 1'b1);
    step(200);
    checks++; if (rx_log.size() != base_rx + 1) begin failures++; $display("FAIL glitch_next_count got=%0d exp=1", rx_log.size() - base_rx); end
    if (rx_log.size() > base_rx) begin
      checks++; if (rx_log[base_rx] !== 9'h041) begin failures++; $display("FAIL glitch_next_data got=%h exp=041", rx_log[base_rx]); end
    end
  endtask

  task automatic test_framing();
    int base_rx;
    base_rx = rx_log.size();
    send_rx(8'h3C, 1'b0);
    step(2000);
    checks++; if (rx_log.size() != base_rx + 1) begin failures++; $display("FAIL break_count got=%0d exp=1", rx_log.size() - base_rx); end
    if (rx_log.size() > base_rx) begin
      checks++; if (rx_log[base_rx] !== 9'h13C) begin failures++; $display("FAIL break_char got=%h exp=13c", rx_log[base_rx]); end
    end
    rxd_drv = 1'b1;
    step(100);
    send_rx(8'h12, 1'b1);
    step(200);
    checks++; if (rx_log.size() != base_rx + 2) begin failures++; $display("FAIL after_break_count got=%0d exp=2", rx_log.size() - base_rx); end
    if (rx_log.size() > base_rx + 1) begin
      checks++; if (rx_log[base_rx+1] !== 9'h012) begin failures++; $display("FAIL after_break_char got=%h exp=012", rx_log[base_rx+1]); end
    end
  endtask

  task automatic test_reset_mid();
    int base_rx, base_done, base_low;
    base_done = done_cnt;
    tx_data = 8'hA5; tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    step(340);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (txd !== 1'b1)     begin failures++; $display("FAIL midtx_txd got=%b exp=1", txd); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL midtx_busy got=%b exp=0", tx_busy); end
    base_low = txd_low;
    step(800);
    checks++; if (done_cnt != base_done) begin failures++; $display("FAIL midtx_done got=%0d exp=0", done_cnt - base_done); end
    checks++; if (txd_low != base_low)  begin failures++; $display("FAIL midtx_line_low got=%0d exp=0", txd_low - base_low); end

    base_rx = rx_log.size();
    rxd_drv = 1'b0;
    step(300);
    reset = 1'b1; rxd_drv = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midrx_valid got=%b exp=0", rx_valid); end
    step(800);
    checks++; if (rx_log.size() != base_rx) begin failures++; $display("FAIL midrx_count got=%0d exp=0", rx_log.size() - base_rx); end

    base_done = done_cnt;
    loop = 1'b1;
    tx_data = 8'h5A; tx_start = 1'b1;
    step(1);
    tx_start = 1'b0;
    step(700);
    checks++; if (done_cnt - base_done != 1) begin failures++; $display("FAIL post_reset_done got=%0d exp=1", done_cnt - base_done); end
    checks++; if (rx_log.size() != base_rx + 1) begin failures++; $display("FAIL post_reset_rx_count got=%0d exp=1", rx_log.size() - base_rx); end
    if (rx_log.size() > base_rx) begin
      checks++; if (rx_log[base_rx] !== 9'h05A) begin failures++; $display("FAIL post_reset_rx got=%h exp=05a", rx_log[base_rx]); end
    end
    loop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
